// File: rtl/alu_issue.sv
// Issue stage for the combinational ALU: decodes one RV32I/M request per handshake,
// holds the ALU operands for the op's cycle count and returns the tagged result.
module alu_issue #(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 8
) (
   input  logic        clk,
   input  logic        areset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_kind,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [4:0]  in_tag,
   output logic [31:0] alu_src_a,
   output logic [31:0] alu_src_b,
   output logic [3:0]  alu_instr,
   input  logic [31:0] alu_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [4:0]  out_tag,
   output logic        out_illegal
);

   localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             inv_p0;
   logic [5:0]       dec;
   logic             accept;

   // Returns {legal, invert, op}.
   function automatic logic [5:0] decode(input logic [1:0] kind, input logic [2:0] f3,
                                         input logic [6:0] f7);
      logic       legal;
      logic       inv;
      logic [3:0] op;
      legal = 1'b1;
      inv   = 1'b0;
      op    = 4'h0;
      case (kind)
         2'b00, 2'b01: begin
            if (kind == 2'b00 && f7 == 7'h01) begin
               case (f3)
                  3'd0:    op = 4'hD;
                  3'd4:    op = 4'hE;
                  3'd6:    op = 4'hF;
                  default: legal = 1'b0;
               endcase
            end else begin
               case (f3)
                  3'd0:    op = (kind == 2'b00 && f7 == 7'h20) ? 4'h1 : 4'h0;
                  3'd1:    op = 4'h5;
                  3'd2:    op = 4'h7;
                  3'd3:    op = 4'hB;
                  3'd4:    op = 4'h4;
                  3'd5:    op = 4'h6;
                  3'd6:    op = 4'h3;
                  default: op = 4'h2;
               endcase
               // Register forms only tolerate the SUB encoding; immediates only care on shifts.
               if (kind == 2'b00 && f7 != 7'h00 && !(f3 == 3'd0 && f7 == 7'h20))
                  legal = 1'b0;
               if (kind == 2'b01 && (f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00)
                  legal = 1'b0;
            end
         end
         2'b10: begin
            case (f3)
               3'd0:    op = 4'h8;
               3'd1:    op = 4'h9;
               3'd4:    op = 4'h7;
               3'd5:    op = 4'hA;
               3'd6:    op = 4'hB;
               3'd7:    begin op = 4'hB; inv = 1'b1; end
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase
      return {legal, inv, op};
   endfunction

   always_comb begin
      dec = decode(in_kind, in_funct3, in_funct7);
   end

   assign in_ready = !areset && (state == IDLE || (state == DONE && out_ready));
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state       <= IDLE;
         cnt         <= '0;
         inv_p0      <= 1'b0;
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_tag     <= '0;
         out_illegal <= 1'b0;
         alu_src_a   <= '0;
         alu_src_b   <= '0;
         alu_instr   <= '0;
      end else if (accept) begin
         out_tag <= in_tag;
         if (dec[5]) begin
            alu_src_a <= in_a;
            alu_src_b <= in_b;
            alu_instr <= dec[3:0];
            inv_p0    <= dec[4];
            out_valid <= 1'b0;
            state     <= EXEC;
            if (dec[3:0] == 4'hD)
               cnt <= CNT_W'(MUL_CYCLES - 1);
            else if (dec[3:0] == 4'hE || dec[3:0] == 4'hF)
               cnt <= CNT_W'(DIV_CYCLES - 1);
            else
               cnt <= '0;
         end else begin
            // Undecodable requests skip the ALU and report straight away.
            out_valid   <= 1'b1;
            out_illegal <= 1'b1;
            out_result  <= '0;
            state       <= DONE;
         end
      end else begin
         case (state)
            EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  out_result  <= inv_p0 ? {31'b0, ~alu_result[0]} : alu_result;
                  out_illegal <= 1'b0;
                  out_valid   <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
